time_set_controller: RTL

Sequencing and time-setting controller for the wall-clock timekeeping chain. Holds hours/minutes/seconds, advances them on a 1 Hz tick in normal operation, and runs a button-driven state machine so the user can set hours, then minutes. It sits between the debounced front-panel buttons and the display decoders, and replaces free-running counter cascading with controlled load/hold/advance sequencing.

---
 rtl/time_set_controller.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/time_set_controller.sv
// time_set_controller
//   Wall-clock timekeeping and time-setting sequencer. Holds hours, minutes
//   and seconds, advances them on the 1 Hz tick while running, and walks a
//   button-driven state machine (RUN -> SET_HOUR -> SET_MIN -> RUN) so the
//   user can set the time.
//
//   Optional build macro: AUTO_REPEAT_EN. When it is defined, holding btnInc
//   in a SET state auto-repeats the increment after REPEAT_HOLD cycles, then
//   repeats every REPEAT_PERIOD cycles. REPEAT_PERIOD is assumed to be no
//   larger than REPEAT_HOLD.
//
// Ports
//   clk      in   system clock, rising edge
//   nReset   in   asynchronous active-low reset
//   tick     in   one-clk pulse at 1 Hz
//   btnMode  in   debounced mode button (level)
//   btnInc   in   debounced increment button (level)
//   hours    out  current hour   0..HOUR_MAX
//   minutes  out  current minute 0..MIN_MAX
//   seconds  out  current second 0..SEC_MAX
//   state    out  0 RUN, 1 SET_HOUR, 2 SET_MIN
//   blink    out  field-blink strobe, 0 in RUN
module time_set_controller #(
  parameter logic [4:0]  HOUR_MAX      = 5'd23,
  parameter logic [5:0]  MIN_MAX       = 6'd59,
  parameter logic [5:0]  SEC_MAX       = 6'd59,
  parameter logic [15:0] REPEAT_HOLD   = 16'd50000,
  parameter logic [15:0] REPEAT_PERIOD = 16'd10000
) (
  input  logic       clk,
  input  logic       nReset,
  input  logic       tick,
  input  logic       btnMode,
  input  logic       btnInc,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [1:0] state,
  output logic       blink
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    ILLEGAL  = 2'd3
  } state_t;

  // Wrapping increments: any value at or beyond the limit returns to 0, so
  // an out-of-range register heals itself on its next advance.
  function automatic logic [5:0] incWrap6(input logic [5:0] v, input logic [5:0] maxV);
    return (v >= maxV) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [4:0] incWrap5(input logic [4:0] v, input logic [4:0] maxV);
    return (v >= maxV) ? 5'd0 : v + 5'd1;
  endfunction

  state_t     stateQ, stateD;
  logic [4:0] hoursQ, hoursD;
  logic [5:0] minutesQ, minutesD;
  logic [5:0] secondsQ, secondsD;
  logic       blinkQ, blinkD;
  logic       modePrev, incPrev;
  logic       modeEdge, incEdge, incStep;

  assign modeEdge = btnMode & ~modePrev;
  assign incEdge  = btnInc & ~incPrev;

`ifdef AUTO_REPEAT_EN
  logic [15:0] holdCnt;
  logic        inSet;
  logic        repeatFire;

  assign inSet      = (stateQ == SET_HOUR) || (stateQ == SET_MIN);
  assign repeatFire = inSet && btnInc && (holdCnt == REPEAT_HOLD);
  assign incStep    = incEdge | repeatFire;

  // holdCnt counts held cycles; after a repeat it is rewound so that the
  // next match lands exactly REPEAT_PERIOD cycles later.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      holdCnt <= '0;
    end else if (!btnInc || !inSet || (stateD != stateQ)) begin
      holdCnt <= '0;
    end else if (repeatFire) begin
      holdCnt <= REPEAT_HOLD - REPEAT_PERIOD + 16'd1;
    end else if (holdCnt != 16'hFFFF) begin
      holdCnt <= holdCnt + 16'd1;
    end
  end
`else
  logic unusedRepeatCfg;
  assign unusedRepeatCfg = ^{REPEAT_HOLD, REPEAT_PERIOD};
  assign incStep         = incEdge;
`endif

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      stateQ   <= RUN;
      hoursQ   <= '0;
      minutesQ <= '0;
      secondsQ <= '0;
      blinkQ   <= 1'b0;
      // History starts high so a button held through reset gives no edge.
      modePrev <= 1'b1;
      incPrev  <= 1'b1;
    end else begin
      stateQ   <= stateD;
      hoursQ   <= hoursD;
      minutesQ <= minutesD;
      secondsQ <= secondsD;
      blinkQ   <= blinkD;
      modePrev <= btnMode;
      incPrev  <= btnInc;
    end
  end

  always_comb begin
    stateD   = stateQ;
    hoursD   = hoursQ;
    minutesD = minutesQ;
    secondsD = secondsQ;
    blinkD   = blinkQ;
    unique case (stateQ)
      RUN: begin
        blinkD = 1'b0;
        // Mode takes priority: a coincident tick is dropped.
        if (modeEdge) begin
          stateD   = SET_HOUR;
          secondsD = '0;
          blinkD   = 1'b1;
        end else if (tick) begin
          secondsD = incWrap6(secondsQ, SEC_MAX);
          if (secondsQ >= SEC_MAX) begin
            minutesD = incWrap6(minutesQ, MIN_MAX);
            if (minutesQ >= MIN_MAX) begin
              hoursD = incWrap5(hoursQ, HOUR_MAX);
            end
          end
        end
      end
      SET_HOUR: begin
        if (modeEdge) begin
          stateD = SET_MIN;
        end else if (incStep) begin
          hoursD = incWrap5(hoursQ, HOUR_MAX);
        end
        if (tick) begin
          blinkD = ~blinkQ;
        end
      end
      SET_MIN: begin
        if (modeEdge) begin
          stateD   = RUN;
          secondsD = '0;
          blinkD   = 1'b0;
        end else begin
          if (incStep) begin
            minutesD = incWrap6(minutesQ, MIN_MAX);
          end
          if (tick) begin
            blinkD = ~blinkQ;
          end
        end
      end
      default: begin
        // Illegal encoding: return to RUN, keep the time.
        stateD = RUN;
        blinkD = 1'b0;
      end
    endcase
  end

  assign hours   = hoursQ;
  assign minutes = minutesQ;
  assign seconds = secondsQ;
  assign state   = stateQ;
  assign blink   = blinkQ;

endmodule
